// File: rtl/bcd_event_counter.sv
// -----------------------------------------------------------------------------
// bcd_event_counter
//   Front end of the six-digit 7-segment display path. Two raw active-low
//   pushbuttons are synchronised, debounced and edge-detected into one-cycle
//   press strobes which step a NUM_DIGITS-digit BCD counter up or down.
//
// Ports
//   CLOCK_50  in   system clock, all state on the rising edge
//   RESET_N   in   asynchronous active-low reset
//   KEY_UP_N  in   raw up pushbutton, 0 = pressed, asynchronous
//   KEY_DN_N  in   raw down pushbutton, 0 = pressed, asynchronous
//   CLEAR     in   synchronous clear of the count, priority over presses
//   DIGITS    out  registered BCD count, digit 0 in [3:0]
//   UP_PULSE  out  one-cycle strobe per accepted up press
//   DN_PULSE  out  one-cycle strobe per accepted down press
//   WRAP      out  one-cycle strobe, aligned with DIGITS, on wrap/saturation
//
// Configuration
//   BCD_SATURATE_EN  defined: count holds at all-9 (up) / all-0 (down)
//                    undefined (default): count wraps around
// -----------------------------------------------------------------------------
module bcd_event_counter #(
  parameter int NUM_DIGITS      = 6,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_W           = 20
) (
  input  logic                    CLOCK_50,
  input  logic                    RESET_N,
  input  logic                    KEY_UP_N,
  input  logic                    KEY_DN_N,
  input  logic                    CLEAR,
  output logic [4*NUM_DIGITS-1:0] DIGITS,
  output logic                    UP_PULSE,
  output logic                    DN_PULSE,
  output logic                    WRAP
);

  // Key index 0 = up, 1 = down throughout.
  localparam int KEYS = 2;
  localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [KEYS-1:0]            sync1_q;
  logic [KEYS-1:0]            sync2_q;
  logic [KEYS-1:0]            deb_q, deb_d;
  logic [KEYS-1:0]            deb_prev_q;
  logic [KEYS-1:0]            pulse_q, pulse_d;
  logic [KEYS-1:0][CNT_W-1:0] cnt_q, cnt_d;
  logic [4*NUM_DIGITS-1:0]    digits_q, digits_d;
  logic                       wrap_q, wrap_d;
  logic                       carry;
  logic [3:0]                 dig;

  // Two-flop synchroniser; idles at 1 (released).
  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      sync1_q <= '1;
      sync2_q <= '1;
    end else begin
      sync1_q <= {KEY_DN_N, KEY_UP_N};
      sync2_q <= sync1_q;
    end
  end

  // Debounce: count consecutive cycles where the synchronised level differs
  // from the accepted level; accept it on the DEBOUNCE_CYCLES-th such cycle.
  always_comb begin
    deb_d = deb_q;
    cnt_d = '0;
    for (int unsigned k = 0; k < KEYS; k++) begin
      if (sync2_q[k] != deb_q[k]) begin
        if (cnt_q[k] == DB_LAST) begin
          deb_d[k] = sync2_q[k];
        end else begin
          cnt_d[k] = cnt_q[k] + CNT_W'(1);
        end
      end
    end
    // Press = accepted 1->0 transition, seen one cycle after acceptance.
    pulse_d = deb_prev_q & ~deb_q;
  end

  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      deb_q      <= '1;
      deb_prev_q <= '1;
      cnt_q      <= '0;
      pulse_q    <= '0;
    end else begin
      deb_q      <= deb_d;
      deb_prev_q <= deb_q;
      cnt_q      <= cnt_d;
      pulse_q    <= pulse_d;
    end
  end

  // BCD counter: carry (up) or borrow (down) ripples from digit 0 upward.
  // A carry/borrow out of the top digit marks a wrap.
  always_comb begin
    digits_d = digits_q;
    wrap_d   = 1'b0;
    carry    = 1'b0;
    dig      = '0;
    if (CLEAR) begin
      digits_d = '0;
    end else if (pulse_q[0] ^ pulse_q[1]) begin
      carry = 1'b1;
      for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
        dig = digits_q[4*i +: 4];
        if (carry) begin
          if (pulse_q[0]) begin
            if (dig == 4'd9) begin
              digits_d[4*i +: 4] = 4'd0;
            end else begin
              digits_d[4*i +: 4] = dig + 4'd1;
              carry              = 1'b0;
            end
          end else begin
            if (dig == 4'd0) begin
              digits_d[4*i +: 4] = 4'd9;
            end else begin
              digits_d[4*i +: 4] = dig - 4'd1;
              carry              = 1'b0;
            end
          end
        end
      end
      if (carry) begin
        wrap_d = 1'b1;
`ifdef BCD_SATURATE_EN
        digits_d = digits_q;  // hold at the boundary value
`else
        // ripple already produced all-0 (up) or all-9 (down)
`endif
      end
    end
  end

  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      digits_q <= '0;
      wrap_q   <= 1'b0;
    end else begin
      digits_q <= digits_d;
      wrap_q   <= wrap_d;
    end
  end

  assign DIGITS   = digits_q;
  assign UP_PULSE = pulse_q[0];
  assign DN_PULSE = pulse_q[1];
  assign WRAP     = wrap_q;

endmodule

// File: tb/tb_bcd_event_counter.sv
// -----------------------------------------------------------------------------
// tb_bcd_event_counter
//   Directed scenarios plus randomized key/clear activity, checked every cycle
//   against a behavioural model (integer count, stable-run debounce).
// -----------------------------------------------------------------------------
module tb_bcd_event_counter;

  localparam int ND   = 6;
  localparam int DB   = 4;
  localparam int CW   = 3;
  localparam int MAXV = 999999;

  logic        clk      = 1'b0;
  logic        rst_n    = 1'b0;
  logic        key_up_n = 1'b1;
  logic        key_dn_n = 1'b1;
  logic        clear    = 1'b0;
  logic [23:0] digits;
  logic        up_p, dn_p, wrap;

  bcd_event_counter #(
    .NUM_DIGITS      (ND),
    .DEBOUNCE_CYCLES (DB),
    .CNT_W           (CW)
  ) dut (
    .CLOCK_50 (clk),
    .RESET_N  (rst_n),
    .KEY_UP_N (key_up_n),
    .KEY_DN_N (key_dn_n),
    .CLEAR    (clear),
    .DIGITS   (digits),
    .UP_PULSE (up_p),
    .DN_PULSE (dn_p),
    .WRAP     (wrap)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [23:0] to_bcd(input int v);
    logic [23:0] r;
    int x;
    r = '0;
    x = v;
    for (int i = 0; i < ND; i++) begin
      r[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  // ---------------- behavioural model ----------------
  int m_val;
  bit m_wrap;
  bit m_pulse [2];
  bit m_deb   [2];
  bit m_debold[2];
  int m_run   [2];
  bit m_hist  [2][2];  // key samples from two and one edges ago
  bit kin     [2];
  bit synced;
  int cyc = 0;

  always @(posedge clk) begin
    cyc++;
    if (!rst_n) begin
      m_val  = 0;
      m_wrap = 0;
      for (int k = 0; k < 2; k++) begin
        m_pulse[k] = 0; m_deb[k] = 1; m_debold[k] = 1; m_run[k] = 0;
        m_hist[k][0] = 1; m_hist[k][1] = 1;
      end
    end else begin
      m_wrap = 0;
      if (clear) begin
        m_val = 0;
      end else if (m_pulse[0] && !m_pulse[1]) begin
        if (m_val == MAXV) begin
          m_wrap = 1;
`ifdef BCD_SATURATE_EN
          m_val = MAXV;
`else
          m_val = 0;
`endif
        end else m_val = m_val + 1;
      end else if (m_pulse[1] && !m_pulse[0]) begin
        if (m_val == 0) begin
          m_wrap = 1;
`ifdef BCD_SATURATE_EN
          m_val = 0;
`else
          m_val = MAXV;
`endif
        end else m_val = m_val - 1;
      end
      kin[0] = key_up_n;
      kin[1] = key_dn_n;
      for (int k = 0; k < 2; k++) begin
        m_pulse[k]  = m_debold[k] && !m_deb[k];
        m_debold[k] = m_deb[k];
        synced      = m_hist[k][0];
        m_hist[k][0] = m_hist[k][1];
        m_hist[k][1] = kin[k];
        if (synced != m_deb[k]) begin
          m_run[k]++;
          if (m_run[k] == DB) begin
            m_deb[k] = synced;
            m_run[k] = 0;
          end
        end else m_run[k] = 0;
      end
    end
  end

  // ---------------- per-cycle checking and event counters ----------------
  int up_cnt = 0, dn_cnt = 0, wrap_cnt = 0, up_last = 0;

  always @(negedge clk) begin
    check("digits", {8'h0, digits}, {8'h0, to_bcd(m_val)});
    check("up_pulse", {31'h0, up_p}, {31'h0, m_pulse[0]});
    check("dn_pulse", {31'h0, dn_p}, {31'h0, m_pulse[1]});
    check("wrap", {31'h0, wrap}, {31'h0, m_wrap});
    for (int i = 0; i < ND; i++)
      check("digit_range", {31'h0, (digits[4*i +: 4] <= 4'd9)}, 32'h1);
    if (up_p) begin up_cnt++; up_last = cyc; end
    if (dn_p) dn_cnt++;
    if (wrap) wrap_cnt++;
  end

  // ---------------- stimulus helpers ----------------
  int fall_cyc;

  task automatic press(input bit up, input bit dn, input int hold);
    @(negedge clk);
    if (up) key_up_n = 1'b0;
    if (dn) key_dn_n = 1'b0;
    fall_cyc = cyc;
    repeat (hold) @(negedge clk);
    key_up_n = 1'b1;
    key_dn_n = 1'b1;
    repeat (12) @(negedge clk);
  endtask

  task automatic pulse_clear();
    @(negedge clk);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  int u0, d0, w0, settle;

  initial begin
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_digits", {8'h0, digits}, 32'h0);

    // single clean press: one pulse, fixed latency, no pulse on release
    u0 = up_cnt;
    press(1, 0, 20);
    check("t2_npulse", up_cnt - u0, 1);
    check("t2_latency", up_last - fall_cyc, 7);
    check("t2_digits", {8'h0, digits}, 32'h000001);

    // bouncing key: pulse only once stable
    u0 = up_cnt;
    @(negedge clk);
    repeat (6) begin
      key_up_n = 1'b0; repeat (2) @(negedge clk);
      key_up_n = 1'b1; repeat (2) @(negedge clk);
    end
    check("t3_bounce_nopulse", up_cnt - u0, 0);
    key_up_n = 1'b0;
    settle   = cyc;
    repeat (12) @(negedge clk);
    key_up_n = 1'b1;
    repeat (12) @(negedge clk);
    check("t3_npulse", up_cnt - u0, 1);
    check("t3_latency", up_last - settle, 7);
    check("t3_digits", {8'h0, digits}, 32'h000002);

    // carry/borrow across digits
    repeat (97) press(1, 0, 6);
    check("t4_preload", {8'h0, digits}, 32'h000099);
    press(1, 0, 6);
    check("t4_up_carry", {8'h0, digits}, 32'h000100);
    press(0, 1, 6);
    check("t4_dn_borrow", {8'h0, digits}, 32'h000099);

    // wrap / saturate at the extremes
    pulse_clear();
    check("t5_clear", {8'h0, digits}, 32'h0);
    w0 = wrap_cnt;
    press(0, 1, 6);
`ifdef BCD_SATURATE_EN
    check("t5_dn_at_zero", {8'h0, digits}, 32'h000000);
`else
    check("t5_dn_at_zero", {8'h0, digits}, 32'h999999);
`endif
    check("t5_dn_wrap", wrap_cnt - w0, 1);
    w0 = wrap_cnt;
    press(1, 0, 6);
`ifdef BCD_SATURATE_EN
    check("t5_up", {8'h0, digits}, 32'h000001);
    check("t5_up_wrap", wrap_cnt - w0, 0);
`else
    check("t5_up_at_max", {8'h0, digits}, 32'h000000);
    check("t5_up_wrap", wrap_cnt - w0, 1);
`endif

    // simultaneous presses, and clear against a press
    pulse_clear();
    press(1, 0, 6);
    u0 = up_cnt; d0 = dn_cnt;
    press(1, 1, 8);
    check("t6_both_up", up_cnt - u0, 1);
    check("t6_both_dn", dn_cnt - d0, 1);
    check("t6_both_digits", {8'h0, digits}, 32'h000001);
    u0 = up_cnt;
    @(negedge clk);
    key_up_n = 1'b0;
    clear    = 1'b1;
    repeat (14) @(negedge clk);
    key_up_n = 1'b1;
    clear    = 1'b0;
    repeat (12) @(negedge clk);
    check("t6_clear_npulse", up_cnt - u0, 1);
    check("t6_clear_digits", {8'h0, digits}, 32'h0);

    // asynchronous reset mid-debounce with a non-zero count
    press(1, 0, 6);
    press(1, 0, 6);
    u0 = up_cnt;
    @(negedge clk);
    key_up_n = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("areset_digits", {8'h0, digits}, 32'h0);
    check("areset_up", {31'h0, up_p}, 32'h0);
    check("areset_dn", {31'h0, dn_p}, 32'h0);
    check("areset_wrap", {31'h0, wrap}, 32'h0);
    @(negedge clk);
    key_up_n = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (15) @(negedge clk);
    check("areset_nopulse", up_cnt - u0, 0);

    // randomized activity, checked cycle by cycle against the model
    repeat (350) begin
      key_up_n = 1'($urandom_range(0, 1));
      key_dn_n = 1'($urandom_range(0, 1));
      clear    = ($urandom_range(0, 19) == 0);
      @(negedge clk);
      clear = 1'b0;
      repeat ($urandom_range(1, 12)) @(negedge clk);
    end
    key_up_n = 1'b1;
    key_dn_n = 1'b1;
    repeat (20) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

endmodule
